dmem_ctrl: RTL and testbench

//  Data-memory controller directly downstream of the CPU core's data port.
//  - Accepts the core's word/half/byte load and store requests and drives a

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane.sv | 45 ++++
 rtl/dmem_ctrl.sv | 134 +++++++++++++
 tb/tb_dmem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// FSM state enum, one-hot size codes, default RAM base address.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE
    } state_e;

    localparam logic [2:0] SW_BYTE = 3'b100;
    localparam logic [2:0] SW_HALF = 3'b010;
    localparam logic [2:0] SW_WORD = 3'b001;

    localparam logic [31:0] DMEM_BASE = 32'h1001_0000;

    function automatic logic sw_onehot(input logic [2:0] s);
        return (s == SW_BYTE) || (s == SW_HALF) || (s == SW_WORD);
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: right-aligned load extract and sub-word store merge.
// Ports: word/ofs/size/wdata in; rdata (extracted), merged (RMW word) out.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  ofs,
    input  logic [2:0]  size,
    input  logic [15:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] ins;

    always_comb begin
        sh      = {ofs, 3'b000};
        shifted = word >> sh;
        rdata   = word;
        mask    = '0;
        ins     = '0;
        case (size)
            SW_BYTE: begin
                rdata = {24'b0, shifted[7:0]};
                mask  = 32'h0000_00ff << sh;
                ins   = {24'b0, wdata[7:0]} << sh;
            end
            SW_HALF: begin
                rdata = {16'b0, shifted[15:0]};
                mask  = 32'h0000_ffff << sh;
                ins   = {16'b0, wdata} << sh;
            end
            default: begin
                rdata = word;
                mask  = '0;
                ins   = '0;
            end
        endcase
        merged = (word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the core data port and a 1-port word RAM.
// Ports: core side cs/we/sw/addr/wdata -> rdata/stall/err/err_addr;
// RAM side mem_en/mem_we/mem_addr/mem_wdata, mem_rdata (1-cycle latency).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          AW       = 10,
    parameter logic [31:0] BASE     = DMEM_BASE,
    parameter int          LOAD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          we,
    input  logic [2:0]    sw,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          stall,
    output logic          err,
    output logic [31:0]   err_addr,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    if (LOAD_LAT != 1) begin : g_lat_chk
        $error("dmem_ctrl: only LOAD_LAT=1 is supported");
    end

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [31:0] off;
    logic        in_win;
    logic        aligned;
    logic        req_ok;
    logic [31:0] lane_rdata;
    logic [31:0] lane_merged;

    logic        stall_c;
    logic        err_c;
    logic        en_c;
    logic        we_c;
    logic [31:0] wd_c;

    // Window test on the offset: upper bits above the RAM span must be 0.
    always_comb begin
        off     = addr - BASE;
        in_win  = (addr >= BASE) && (off[31:AW+2] == '0);
        aligned = 1'b1;
        if (sw == SW_WORD) aligned = (addr[1:0] == 2'b00);
        if (sw == SW_HALF) aligned = (addr[0] == 1'b0);
        req_ok  = cs && sw_onehot(sw) && in_win && aligned;
    end

    dmem_lane u_lane (
        .word   (mem_rdata),
        .ofs    (off[1:0]),
        .size   (sw),
        .wdata  (wdata[15:0]),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;
        stall_c    = 1'b0;
        err_c      = 1'b0;
        en_c       = 1'b0;
        we_c       = 1'b0;
        wd_c       = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs && !req_ok) begin
                    err_c      = 1'b1;
                    err_addr_d = addr;
                    rdata_d    = '0;
                end else if (req_ok) begin
                    en_c = 1'b1;
                    if (we && (sw == SW_WORD)) begin
                        we_c = 1'b1;
                        wd_c = wdata;
                    end else begin
                        stall_c = 1'b1;
                        state_d = we ? ST_MERGE : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = lane_rdata;
                state_d = ST_IDLE;
            end
            ST_MERGE: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                wd_c    = lane_merged;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced to their reset values while rst is held low,
    // so a MERGE write in flight is dropped immediately.
    always_comb begin
        stall     = rst & stall_c;
        err       = rst & err_c;
        mem_en    = rst & en_c;
        mem_we    = rst & we_c;
        mem_addr  = (rst && en_c) ? off[AW+1:2] : '0;
        mem_wdata = rst ? wd_c : '0;
        rdata     = rst ? rdata_d : '0;
        err_addr  = err_addr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rdata_q    <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus random traffic
// compared against a byte-array memory model and per-request rules.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic          clk;
    logic          rst;
    logic          cs;
    logic          we;
    logic [2:0]    sw;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          stall;
    logic          err;
    logic [31:0]   err_addr;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    dmem_ctrl #(
        .AW       (AW),
        .BASE     (BASE),
        .LOAD_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .we        (we),
        .sw        (sw),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .err       (err),
        .err_addr  (err_addr),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [DEPTH];
    logic [7:0]  mdl [4*DEPTH];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int checks;
    int errors;
    int stall_cycles;
    logic [31:0] exp_rdata;
    logic [31:0] exp_err_addr;

    always @(posedge clk) begin
        if (rst && stall) stall_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit mdl_valid(input bit c, input logic [2:0] s,
                                     input logic [31:0] a);
        longint la;
        la = longint'(a);
        if (!c) return 0;
        if (!(s == SW_BYTE || s == SW_HALF || s == SW_WORD)) return 0;
        if (la < longint'(BASE)) return 0;
        if (la >= longint'(BASE) + 4 * DEPTH) return 0;
        if (s == SW_WORD && (a % 4) != 0) return 0;
        if (s == SW_HALF && (a % 2) != 0) return 0;
        return 1;
    endfunction

    function automatic int nbytes(input logic [2:0] s);
        if (s == SW_BYTE) return 1;
        if (s == SW_HALF) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] s,
                                             input logic [31:0] a);
        logic [31:0] v;
        int o;
        o = int'(a - BASE);
        v = '0;
        for (int k = 0; k < nbytes(s); k++) v[8*k +: 8] = mdl[o + k];
        return v;
    endfunction

    function automatic logic [31:0] mdl_word(input logic [31:0] a);
        int o;
        o = int'(a - BASE) & ~3;
        return {mdl[o+3], mdl[o+2], mdl[o+1], mdl[o]};
    endfunction

    task automatic mdl_store(input logic [2:0] s, input logic [31:0] a,
                             input logic [31:0] d);
        int o;
        o = int'(a - BASE);
        for (int k = 0; k < nbytes(s); k++) mdl[o + k] = d[8*k +: 8];
    endtask

    // One core request: drive on negedge, hold through any stall cycle.
    task automatic req(input bit c, input bit w, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d);
        bit ok;
        bit slow;
        logic [31:0] waddr;
        @(negedge clk);
        cs = c; we = w; sw = s; addr = a; wdata = d;
        ok    = mdl_valid(c, s, a);
        slow  = ok && !(w && s == SW_WORD);
        waddr = (a - BASE) >> 2;
        if (c && !ok) exp_rdata = '0;
        #1;
        chk("err", err, c && !ok);
        chk("stall", stall, slow);
        chk("mem_en", mem_en, ok);
        chk("mem_we", mem_we, ok && w && s == SW_WORD);
        chk("rdata_c1", rdata, exp_rdata);
        if (ok) chk("mem_addr", mem_addr, waddr);
        if (ok && w && s == SW_WORD) begin
            chk("mem_wdata", mem_wdata, d);
            mdl_store(s, a, d);
        end
        @(posedge clk);
        if (c && !ok) exp_err_addr = a;
        if (slow) begin
            @(negedge clk);
            #1;
            chk("stall_c2", stall, 0);
            chk("mem_en_c2", mem_en, w);
            chk("mem_we_c2", mem_we, w);
            if (w) begin
                mdl_store(s, a, d);
                chk("merge_word", mem_wdata, mdl_word(a));
                chk("merge_addr", mem_addr, waddr);
            end else begin
                exp_rdata = mdl_load(s, a);
                chk("rdata_ld", rdata, exp_rdata);
            end
            @(posedge clk);
        end
        #1;
        chk("err_addr", err_addr, exp_err_addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int bad;
        bit c;
        bit w;
        logic [2:0] s;
        logic [31:0] a;
        int r;

        checks       = 0;
        errors       = 0;
        stall_cycles = 0;
        exp_rdata    = '0;
        exp_err_addr = '0;
        mem_rdata    = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        for (int i = 0; i < 4 * DEPTH; i++) mdl[i] = '0;

        rst = 1'b0; cs = 1'b0; we = 1'b0; sw = SW_WORD;
        addr = '0; wdata = '0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // word store then word load
        req(1, 1, SW_WORD, BASE + 8, 32'hDEAD_BEEF);
        req(1, 0, SW_WORD, BASE + 8, 32'h0);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);

        // byte RMW
        req(1, 1, SW_BYTE, BASE + 9, 32'hFFFF_FFA5);
        chk("t2_ram", ram[2], 32'hDEAD_A5EF);
        req(1, 0, SW_BYTE, BASE + 9, 32'h0);
        chk("t2_rdata", rdata, 32'h0000_00A5);

        // half RMW
        req(1, 1, SW_HALF, BASE + 10, 32'hABCD_1234);
        chk("t3_ram", ram[2], 32'h1234_A5EF);
        req(1, 0, SW_HALF, BASE + 10, 32'h0);
        chk("t3_rdata", rdata, 32'h0000_1234);

        // errors
        req(1, 0, SW_WORD, 32'h0, 32'h0);
        req(1, 0, SW_WORD, BASE + 2, 32'h0);
        req(1, 0, SW_HALF, BASE + 1, 32'h0);
        chk("t4_err_addr", err_addr, BASE + 1);

        // reset during MERGE
        @(negedge clk);
        cs = 1; we = 1; sw = SW_BYTE; addr = BASE + 8; wdata = 32'h77;
        #1;
        chk("t5_stall", stall, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_mem_we", mem_we, 0);
        chk("t5_mem_en", mem_en, 0);
        chk("t5_stall0", stall, 0);
        chk("t5_err", err, 0);
        chk("t5_rdata", rdata, 0);
        chk("t5_err_addr", err_addr, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        @(negedge clk);
        cs = 0;
        rst = 1'b1;
        exp_rdata    = '0;
        exp_err_addr = '0;
        #1;
        chk("t5_ram", ram[2], 32'h1234_A5EF);

        // back-to-back load then byte store
        s0 = stall_cycles;
        req(1, 0, SW_WORD, BASE + 8, 32'h0);
        req(1, 1, SW_BYTE, BASE + 12, 32'h0000_005A);
        chk("t6_stalls", stall_cycles - s0, 2);
        req(1, 0, SW_WORD, BASE + 12, 32'h0);
        chk("t6_rdata", rdata, 32'h0000_005A);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            c = ($urandom_range(0, 9) != 0);
            w = $urandom_range(0, 1) != 0;
            r = $urandom_range(0, 9);
            if (r == 0)      s = 3'($urandom_range(0, 7));
            else if (r < 4)  s = SW_BYTE;
            else if (r < 7)  s = SW_HALF;
            else             s = SW_WORD;
            r = $urandom_range(0, 19);
            if (r == 0)      a = BASE - 32'($urandom_range(1, 16));
            else if (r == 1) a = BASE + 4 * DEPTH + 32'($urandom_range(0, 15));
            else if (r == 2) a = $urandom;
            else             a = BASE + 32'($urandom_range(0, 63)) * 4
                                      + 32'($urandom_range(0, 3));
            req(c, w, s, a, $urandom);
        end

        @(negedge clk);
        cs = 0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram[i] !== {mdl[4*i+3], mdl[4*i+2], mdl[4*i+1], mdl[4*i]})
                bad++;
        end
        chk("ram_final", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
